// File: rtl/lsu_if.sv
// Bundle of every core-side and bus-side signal of the load/store unit.
// master = the LSU itself, slave = the core plus data memory around it.
interface lsu_if;
  // Every valid/ready pair transfers on a rising edge where both are high.
  // A valid that is raised stays up with its payload stable until that
  // edge. bus_rvalid has no ready: it is a single-cycle pulse per accepted beat.
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  bus_ready, bus_rvalid, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output bus_ready, bus_rvalid, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: byte-addressed core requests to word-aligned bus beats.
// Define LSU_MISALIGNED_EN to split misaligned accesses into two beats.
module lsu (
  input  logic       clk,
  input  logic       rst_n,
  lsu_if.master      io,
  output logic [2:0] dbg_state
);

  // Encoding is fixed for both builds so dbg_state decodes the same way;
  // ISSUE1/WAIT1 are unreachable unless the split feature is enabled.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;
  logic        err_q;
`ifdef LSU_MISALIGNED_EN
  logic [31:0] hi_q;
  logic        mis_q;
  logic [63:0] ld_pair;
`endif

  logic        req_err;
  logic [1:0]  a_q;
  logic [3:0]  mask_q;
  logic [31:0] word_q;
  logic [31:0] ld_sh;
  logic [31:0] ld_ext;

  function automatic logic [2:0] size_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_illegal(input logic st, input logic [2:0] f3);
    if (st) return (f3 > 3'd2);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic is_mis(input logic [1:0] a, input logic [1:0] sz);
    return ({1'b0, a} + size_of(sz)) > 3'd4;
  endfunction

  // Errors are decided at acceptance so they never touch the bus.
  always_comb begin
`ifdef LSU_MISALIGNED_EN
    req_err = is_illegal(io.req_store, io.req_funct3);
`else
    req_err = is_illegal(io.req_store, io.req_funct3) ||
              is_mis(io.req_addr[1:0], io.req_funct3[1:0]);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      lo_q    <= 32'd0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGNED_EN
      hi_q    <= 32'd0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && io.req_valid) begin
        store_q <= io.req_store;
        f3_q    <= io.req_funct3;
        addr_q  <= io.req_addr;
        wdata_q <= io.req_wdata;
        err_q   <= req_err;
      end
      if (state == WAIT0 && io.bus_rvalid) lo_q <= io.bus_rdata;
`ifdef LSU_MISALIGNED_EN
      if (state == WAIT1 && io.bus_rvalid) hi_q <= io.bus_rdata;
`endif
    end
  end

  assign a_q    = addr_q[1:0];
  assign mask_q = mask_of(f3_q[1:0]);
  assign word_q = {addr_q[31:2], 2'b00};

  // Load data: pick n bytes starting at lane a, spanning into the high word.
  always_comb begin
`ifdef LSU_MISALIGNED_EN
    mis_q   = is_mis(a_q, f3_q[1:0]);
    ld_pair = {hi_q, lo_q};
    ld_sh   = ld_pair[{a_q, 3'b000} +: 32];
`else
    ld_sh   = lo_q >> {a_q, 3'b000};
`endif
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_ext = {24'd0, ld_sh[7:0]};
      3'b101:  ld_ext = {16'd0, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  always_comb begin
    state_nx      = state;
    io.req_ready  = 1'b0;
    io.resp_valid = 1'b0;
    io.resp_rdata = 32'd0;
    io.resp_err   = 1'b0;
    io.bus_valid  = 1'b0;
    io.bus_we     = 1'b0;
    io.bus_addr   = 32'd0;
    io.bus_wdata  = 32'd0;
    io.bus_wstrb  = 4'd0;
    case (state)
      IDLE: begin
        io.req_ready = 1'b1;
        if (io.req_valid) state_nx = req_err ? RESP : ISSUE0;
      end
      ISSUE0: begin
        io.bus_valid = 1'b1;
        io.bus_we    = store_q;
        io.bus_addr  = word_q;
        if (store_q) begin
          io.bus_wstrb = mask_q << a_q;
          io.bus_wdata = wdata_q << {a_q, 3'b000};
        end
        if (io.bus_ready) state_nx = WAIT0;
      end
      WAIT0: begin
`ifdef LSU_MISALIGNED_EN
        if (io.bus_rvalid) state_nx = mis_q ? ISSUE1 : RESP;
`else
        if (io.bus_rvalid) state_nx = RESP;
`endif
      end
`ifdef LSU_MISALIGNED_EN
      ISSUE1: begin
        // Second beat carries the bytes that spilled past the word boundary.
        io.bus_valid = 1'b1;
        io.bus_we    = store_q;
        io.bus_addr  = {addr_q[31:2] + 30'd1, 2'b00};
        if (store_q) begin
          io.bus_wstrb = mask_q >> (3'd4 - {1'b0, a_q});
          io.bus_wdata = wdata_q >> {3'd4 - {1'b0, a_q}, 3'b000};
        end
        if (io.bus_ready) state_nx = WAIT1;
      end
      WAIT1: begin
        if (io.bus_rvalid) state_nx = RESP;
      end
`endif
      RESP: begin
        io.resp_valid = 1'b1;
        io.resp_err   = err_q;
        io.resp_rdata = (err_q || store_q) ? 32'd0 : ld_ext;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dbg_state = state;

endmodule
